// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: instruction classes,
// FSM state encoding and PC step sizes.
package pc_pkg;

   typedef enum logic [3:0] {
      INST_LOAD  = 4'd0,
      INST_IMM   = 4'd1,
      INST_STORE = 4'd2,
      INST_REG   = 4'd3,
      INST_LUI   = 4'd4,
      INST_AUIPC = 4'd5,
      INST_BRNCH = 4'd6,
      INST_JALR  = 4'd7,
      INST_JAL   = 4'd8
   } inst_type_e;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      TRAP = 2'd2
   } pc_state_e;

   localparam logic [2:0] STEP_FULL = 3'd4;
   localparam logic [2:0] STEP_HALF = 3'd2;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC computation: sequential step, branch/jal offset,
// jalr register target, plus the alignment check on the chosen target.
module pc_target_calc
   import pc_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int COMPRESSED = 0
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] imm,
   input  logic [3:0]      inst_type,
   input  logic            branch_taken,
   input  logic [2:0]      step,
   output logic [XLEN-1:0] target,
   output logic [XLEN-1:0] link_pc,
   output logic            misaligned
);

   logic [XLEN-1:0] step_ext;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] rel_pc;
   logic [XLEN-1:0] reg_sum;

   assign step_ext = {{(XLEN-3){1'b0}}, step};
   assign seq_pc   = pc + step_ext;
   assign rel_pc   = pc + imm;
   assign reg_sum  = rs1 + imm;
   assign link_pc  = seq_pc;

   always_comb begin
      target = seq_pc;
      case (inst_type)
         INST_JAL:   target = rel_pc;
         INST_BRNCH: target = branch_taken ? rel_pc : seq_pc;
         INST_JALR:  target = reg_sum & ~{{(XLEN-1){1'b0}}, 1'b1};
         default:    target = seq_pc;
      endcase
   end

   // Bit 0 can only be set here by an odd imm on jal or a taken branch.
   assign misaligned = target[0] | ((COMPRESSED == 0) & target[1]);

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register with boot/run/trap sequencing, fetch back-pressure,
// external redirects and misaligned-target trap capture.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  BOOT  | reset just released, pc held at RESET_VECTOR, pc not valid
//  RUN   | normal flow, pc advances on instr_valid & fetch_ready
//  TRAP  | misaligned target captured, waiting for trap_ack or redirect
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
   parameter int              COMPRESSED   = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      inst_type,
   input  logic            instr_valid,
   input  logic            is_compressed,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1,
   input  logic            fetch_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            trap_ack,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   output logic [XLEN-1:0] link_pc,
   output logic            trap_valid,
   output logic [XLEN-1:0] trap_pc,
   output logic [XLEN-1:0] trap_tval
);

   localparam logic [XLEN-1:0] ALIGN_MASK = (COMPRESSED != 0) ?
      ~{{(XLEN-1){1'b0}}, 1'b1} : ~{{(XLEN-2){1'b0}}, 2'b11};

   pc_state_e       state;
   logic [2:0]      step;
   logic [XLEN-1:0] target;
   logic            misaligned;
   logic [XLEN-1:0] redirect_aligned;
   logic            advance;

   assign step             = ((COMPRESSED != 0) && is_compressed) ? STEP_HALF : STEP_FULL;
   assign redirect_aligned = redirect_pc & ALIGN_MASK;
   assign advance          = instr_valid & fetch_ready;

   pc_target_calc #(
      .XLEN       (XLEN),
      .COMPRESSED (COMPRESSED)
   ) u_target_calc (
      .pc           (pc),
      .rs1          (rs1),
      .imm          (imm),
      .inst_type    (inst_type),
      .branch_taken (branch_taken),
      .step         (step),
      .target       (target),
      .link_pc      (link_pc),
      .misaligned   (misaligned)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BOOT;
         pc         <= RESET_VECTOR;
         pc_valid   <= 1'b0;
         trap_valid <= 1'b0;
         trap_pc    <= '0;
         trap_tval  <= '0;
      end else begin
         case (state)
            BOOT: begin
               state    <= RUN;
               pc_valid <= 1'b1;
            end
            RUN: begin
               if (redirect_valid) begin
                  pc         <= redirect_aligned;
                  trap_valid <= 1'b0;
               end else if (advance) begin
                  if (misaligned) begin
                     trap_valid <= 1'b1;
                     trap_pc    <= pc;
                     trap_tval  <= target;
                     state      <= TRAP;
                     pc_valid   <= 1'b0;
                  end else begin
                     pc <= target;
                  end
               end
            end
            TRAP: begin
               // Redirect outranks the acknowledge so debug/mret entry is never lost.
               if (redirect_valid) begin
                  pc         <= redirect_aligned;
                  trap_valid <= 1'b0;
                  state      <= RUN;
                  pc_valid   <= 1'b1;
               end else if (trap_ack) begin
                  pc         <= TRAP_VECTOR;
                  trap_valid <= 1'b0;
                  state      <= RUN;
                  pc_valid   <= 1'b1;
               end
            end
            default: begin
               state    <= BOOT;
               pc_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: one instance with 4-byte alignment, one with
// compressed stepping, both driven by the same stimulus and checked against a model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  itype;
   logic        iv, is_comp, taken, fr, rv, ack;
   logic [31:0] imm, rs1, rpc;

   logic [31:0] pc0, link0, tpc0, ttval0, pc1, link1, tpc1, ttval1;
   logic        pcv0, tv0, pcv1, tv1;

   logic [31:0] d_pc[2], d_link[2], d_tpc[2], d_ttval[2];
   logic        d_pcv[2], d_tv[2];

   // model state: mode 0 = waiting after reset, 1 = running, 2 = trapped
   int          m_mode[2];
   logic [31:0] m_pc[2], m_tpc[2], m_ttval[2];
   logic        m_pcv[2], m_tv[2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .COMPRESSED(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .inst_type(itype), .instr_valid(iv), .is_compressed(is_comp),
      .branch_taken(taken), .imm(imm), .rs1(rs1), .fetch_ready(fr), .redirect_valid(rv),
      .redirect_pc(rpc), .trap_ack(ack), .pc(pc0), .pc_valid(pcv0), .link_pc(link0),
      .trap_valid(tv0), .trap_pc(tpc0), .trap_tval(ttval0));

   pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .COMPRESSED(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .inst_type(itype), .instr_valid(iv), .is_compressed(is_comp),
      .branch_taken(taken), .imm(imm), .rs1(rs1), .fetch_ready(fr), .redirect_valid(rv),
      .redirect_pc(rpc), .trap_ack(ack), .pc(pc1), .pc_valid(pcv1), .link_pc(link1),
      .trap_valid(tv1), .trap_pc(tpc1), .trap_tval(ttval1));

   assign d_pc[0] = pc0;     assign d_pc[1] = pc1;
   assign d_link[0] = link0; assign d_link[1] = link1;
   assign d_tpc[0] = tpc0;   assign d_tpc[1] = tpc1;
   assign d_ttval[0] = ttval0; assign d_ttval[1] = ttval1;
   assign d_pcv[0] = pcv0;   assign d_pcv[1] = pcv1;
   assign d_tv[0] = tv0;     assign d_tv[1] = tv1;

   function automatic int ref_step(input int c);
      return (c == 1 && is_comp) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_target(input logic [31:0] p, input int c);
      logic [31:0] s;
      if (itype == 4'd8 || (itype == 4'd6 && taken)) return p + imm;
      if (itype == 4'd7) begin
         s = rs1 + imm;
         return s - (s % 2);
      end
      return p + ref_step(c);
   endfunction

   function automatic bit ref_misaligned(input logic [31:0] t, input int c);
      return (c == 1) ? (t % 2 != 0) : (t % 4 != 0);
   endfunction

   function automatic logic [31:0] ref_align(input logic [31:0] a, input int c);
      return (c == 1) ? a - (a % 2) : a - (a % 4);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = 0; m_pc[i] = 32'h0; m_pcv[i] = 1'b0;
         m_tv[i] = 1'b0; m_tpc[i] = 32'h0; m_ttval[i] = 32'h0;
      end
   endtask

   task automatic idle_inputs();
      itype = 4'd3; iv = 0; is_comp = 0; taken = 0; fr = 1; rv = 0; ack = 0;
      imm = 0; rs1 = 0; rpc = 0;
   endtask

   // One clock edge with the currently driven inputs; model follows the edge.
   task automatic apply();
      logic [31:0] t;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (m_mode[i] == 0) begin
            m_mode[i] = 1; m_pcv[i] = 1'b1;
         end else if (rv) begin
            m_pc[i] = ref_align(rpc, i); m_tv[i] = 1'b0; m_mode[i] = 1; m_pcv[i] = 1'b1;
         end else if (m_mode[i] == 1 && iv && fr) begin
            t = ref_target(m_pc[i], i);
            if (ref_misaligned(t, i)) begin
               m_tv[i] = 1'b1; m_tpc[i] = m_pc[i]; m_ttval[i] = t;
               m_mode[i] = 2; m_pcv[i] = 1'b0;
            end else begin
               m_pc[i] = t;
            end
         end else if (m_mode[i] == 2 && ack) begin
            m_pc[i] = 32'h100; m_tv[i] = 1'b0; m_mode[i] = 1; m_pcv[i] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic goto_pc(input logic [31:0] a);
      idle_inputs(); rv = 1; rpc = a;
      apply();
      rv = 0;
   endtask

   task automatic test_reset();
      idle_inputs(); rst_n = 0; model_reset();
      #12;
      total++; if (pc0 !== 32'h0) begin bad++; $display("FAIL reset_pc got %h exp 0", pc0); end
      total++; if (pcv0 !== 1'b0 || pcv1 !== 1'b0) begin bad++; $display("FAIL reset_pc_valid got %b%b exp 00", pcv0, pcv1); end
      total++; if (tv0 !== 1'b0 || tpc0 !== 32'h0 || ttval0 !== 32'h0) begin bad++; $display("FAIL reset_trap got %b %h %h exp 0 0 0", tv0, tpc0, ttval0); end
      @(negedge clk); rst_n = 1;
      #1;
      total++; if (pcv0 !== 1'b0) begin bad++; $display("FAIL boot_pc_valid got %b exp 0", pcv0); end
      apply();
      total++; if (pcv0 !== 1'b1 || pcv1 !== 1'b1 || pc0 !== 32'h0) begin bad++; $display("FAIL run_entry got pcv=%b pc=%h exp 1 0", pcv0, pc0); end
   endtask

   task automatic test_sequential();
      idle_inputs(); iv = 1; itype = 4'd3;
      for (int k = 1; k <= 4; k++) begin
         apply();
         total++; if (pc0 !== 32'(4 * k) || pc1 !== 32'(4 * k)) begin bad++; $display("FAIL seq_%0d got %h/%h exp %h", k, pc0, pc1, 32'(4 * k)); end
      end
   endtask

   task automatic test_branch();
      goto_pc(32'h100);
      iv = 1; itype = 4'd6; taken = 1; imm = 32'h20; apply();
      total++; if (pc0 !== 32'h120) begin bad++; $display("FAIL br_taken got %h exp 120", pc0); end
      taken = 0; apply();
      total++; if (pc0 !== 32'h124) begin bad++; $display("FAIL br_not_taken got %h exp 124", pc0); end
      itype = 4'd8; imm = -32'sd16; apply();
      total++; if (pc0 !== 32'h114) begin bad++; $display("FAIL jal got %h exp 114", pc0); end
      itype = 4'd7; rs1 = 32'h2001; imm = 0; #1;
      total++; if (link0 !== 32'h118) begin bad++; $display("FAIL jalr_link got %h exp 118", link0); end
      apply();
      total++; if (pc0 !== 32'h2000 || tv0 !== 1'b0) begin bad++; $display("FAIL jalr got %h tv=%b exp 2000 0", pc0, tv0); end
   endtask

   task automatic test_backpressure();
      goto_pc(32'h40);
      iv = 1; fr = 0; itype = 4'd1;
      for (int k = 0; k < 3; k++) begin
         apply();
         total++; if (pc0 !== 32'h40) begin bad++; $display("FAIL stall_%0d got %h exp 40", k, pc0); end
      end
      fr = 1; apply();
      total++; if (pc0 !== 32'h44) begin bad++; $display("FAIL stall_release got %h exp 44", pc0); end
   endtask

   task automatic test_trap();
      goto_pc(32'h80);
      iv = 1; itype = 4'd7; rs1 = 32'h202; imm = 0; apply();
      total++; if (tv0 !== 1'b1 || tpc0 !== 32'h80 || ttval0 !== 32'h202) begin bad++; $display("FAIL trap_capture got %b %h %h exp 1 80 202", tv0, tpc0, ttval0); end
      total++; if (pcv0 !== 1'b0 || pc0 !== 32'h80) begin bad++; $display("FAIL trap_hold got pcv=%b pc=%h exp 0 80", pcv0, pc0); end
      total++; if (pc1 !== 32'h202 || tv1 !== 1'b0) begin bad++; $display("FAIL comp_jalr got %h tv=%b exp 202 0", pc1, tv1); end
      itype = 4'd8; imm = 32'h40; apply();
      total++; if (pc0 !== 32'h80 || tv0 !== 1'b1) begin bad++; $display("FAIL trap_ignore got %h tv=%b exp 80 1", pc0, tv0); end
      iv = 0; ack = 1; apply(); ack = 0;
      total++; if (pc0 !== 32'h100 || tv0 !== 1'b0 || pcv0 !== 1'b1) begin bad++; $display("FAIL trap_ack got %h tv=%b pcv=%b exp 100 0 1", pc0, tv0, pcv0); end
      total++; if (tpc0 !== 32'h80 || ttval0 !== 32'h202) begin bad++; $display("FAIL trap_info_hold got %h %h exp 80 202", tpc0, ttval0); end
   endtask

   task automatic test_compressed();
      goto_pc(32'h10);
      iv = 1; itype = 4'd3; is_comp = 1; #1;
      total++; if (link1 !== 32'h12 || link0 !== 32'h14) begin bad++; $display("FAIL comp_link got %h/%h exp 14/12", link0, link1); end
      apply();
      total++; if (pc1 !== 32'h12 || pc0 !== 32'h14) begin bad++; $display("FAIL comp_step got %h/%h exp 14/12", pc0, pc1); end
   endtask

   task automatic test_wrap();
      goto_pc(32'hFFFF_FFFC);
      iv = 1; itype = 4'd5; apply();
      total++; if (pc0 !== 32'h0 || tv0 !== 1'b0) begin bad++; $display("FAIL wrap got %h tv=%b exp 0 0", pc0, tv0); end
   endtask

   task automatic test_priority();
      goto_pc(32'h80);
      iv = 1; itype = 4'd7; rs1 = 32'h202; imm = 0; apply();
      iv = 0; rv = 1; rpc = 32'h403; ack = 1; apply(); rv = 0; ack = 0;
      total++; if (pc0 !== 32'h400 || tv0 !== 1'b0 || pcv0 !== 1'b1) begin bad++; $display("FAIL redir_vs_ack got %h tv=%b exp 400 0", pc0, tv0); end
      total++; if (pc1 !== 32'h402) begin bad++; $display("FAIL redir_comp got %h exp 402", pc1); end
      iv = 1; itype = 4'd8; imm = 32'h6; rv = 1; rpc = 32'h500; apply(); rv = 0;
      total++; if (pc0 !== 32'h500 || tv0 !== 1'b0) begin bad++; $display("FAIL redir_vs_advance got %h tv=%b exp 500 0", pc0, tv0); end
      apply();
      total++; if (tv0 !== 1'b1 || ttval0 !== 32'h506) begin bad++; $display("FAIL odd_imm_trap got tv=%b %h exp 1 506", tv0, ttval0); end
      iv = 0;
      @(negedge clk); rst_n = 0; #1;
      total++; if (pc0 !== 32'h0 || tv0 !== 1'b0 || pcv0 !== 1'b0 || tpc0 !== 32'h0) begin bad++; $display("FAIL async_reset got %h tv=%b pcv=%b tpc=%h exp 0 0 0 0", pc0, tv0, pcv0, tpc0); end
      model_reset();
      #7; rst_n = 1; #1;
      apply();
      total++; if (pcv0 !== 1'b1 || pc0 !== 32'h0) begin bad++; $display("FAIL reboot got pcv=%b pc=%h exp 1 0", pcv0, pc0); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         itype   = 4'($urandom_range(0, 15));
         iv      = ($urandom_range(0, 3) != 0);
         fr      = ($urandom_range(0, 3) != 0);
         is_comp = 1'($urandom_range(0, 1));
         taken   = 1'($urandom_range(0, 1));
         rs1     = $urandom;
         imm     = $urandom;
         if ($urandom_range(0, 3) != 0) imm = 32'($signed(imm[11:0])) & ~32'h3;
         if ($urandom_range(0, 3) != 0) rs1 = rs1 & ~32'h3;
         rv      = ($urandom_range(0, 11) == 0);
         rpc     = $urandom;
         ack     = ($urandom_range(0, 2) == 0);
         #1;
         for (int i = 0; i < 2; i++) begin
            total++;
            if (d_link[i] !== m_pc[i] + 32'(ref_step(i))) begin
               bad++; $display("FAIL rand_link[%0d] n=%0d got %h exp %h", i, n, d_link[i], m_pc[i] + 32'(ref_step(i)));
            end
         end
         apply();
         for (int i = 0; i < 2; i++) begin
            total++;
            if (d_pc[i] !== m_pc[i] || d_pcv[i] !== m_pcv[i] || d_tv[i] !== m_tv[i] ||
                d_tpc[i] !== m_tpc[i] || d_ttval[i] !== m_ttval[i]) begin
               bad++;
               $display("FAIL rand_state[%0d] n=%0d got pc=%h v=%b tv=%b tpc=%h tval=%h exp pc=%h v=%b tv=%b tpc=%h tval=%h",
                        i, n, d_pc[i], d_pcv[i], d_tv[i], d_tpc[i], d_ttval[i],
                        m_pc[i], m_pcv[i], m_tv[i], m_tpc[i], m_ttval[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_backpressure();
      test_trap();
      test_compressed();
      test_wrap();
      test_priority();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
